// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmit state encoding, frame defaults and
// the per-frame configuration snapshot taken when a byte is accepted.
package uart_defs;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_DIV_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        START,
        DATA,
        PARITY,
        STOP
    } TxState_t;

    typedef struct packed {
        logic                  parity_en;
        logic                  parity_odd;
        logic                  stop2;
        logic [UART_DIV_W-1:0] div;
    } TxFrameCfg_t;

endpackage : uart_defs

// File: rtl/uart_tx_baud_gen.sv
// Baud-rate divider: counts clock cycles while enabled and emits a
// one-cycle tick on the last cycle of every bit period. A divisor of 0
// behaves like 1, so a tick then fires on every cycle.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last;

    // Terminal count of the bit period; 0 and 1 both yield a terminal count of 0.
    assign last   = (div_i == '0) ? '0 : div_i - 1'b1;
    assign tick_o = !clr_i && (cnt_q == last);

    // Next count: hold at zero while cleared, otherwise count and wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// UART transmit serializer. Accepts one byte over valid/ready, requests
// the line from flow control, and once granted shifts out start, data
// (LSB first), optional parity and one or two stop bits. Configuration
// is captured at acceptance so later input changes do not disturb a frame.
module uart_tx
    import uart_defs::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DIV_W  = UART_DIV_W
) (
    input  logic              tck,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    input  logic              stop2_i,
    output logic              tx_rts_n_o,
    input  logic              tx_cts_n_i,
    input  logic              tx_enable_i,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // The divisor is carried in the shared config struct, so it must fit.
    if (DIV_W > UART_DIV_W) begin : g_div_w_check
        $error("uart_tx: DIV_W exceeds UART_DIV_W");
    end

    TxState_t          state_q, state_d;
    TxFrameCfg_t       cfg_q, cfg_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              dpar_q, dpar_d;
    logic              tx_q, tx_d;
    logic              rts_n_q, rts_n_d;
    logic              busy_q, busy_d;
    logic              baud_clr;
    logic              baud_tick;

    // Baud counter idles cleared, so it starts from zero on entry to START.
    assign baud_clr = (state_q == IDLE) || (state_q == REQ);

    uart_baud_gen #(
        .DIV_W (UART_DIV_W)
    ) u_baud (
        .clk    (tck),
        .rst    (rst),
        .clr_i  (baud_clr),
        .div_i  (cfg_q.div),
        .tick_o (baud_tick)
    );

    assign ready_o    = (state_q == IDLE) && !rst;
    assign tx_o       = tx_q;
    assign tx_rts_n_o = rts_n_q;
    assign busy_o     = busy_q;

    // Next-state logic; line outputs are decoded from the next state so
    // they appear registered in the same cycle the state takes effect.
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        dpar_d   = dpar_q;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shift_d          = data_i;
                    dpar_d           = ^data_i;
                    cfg_d.parity_en  = parity_en_i;
                    cfg_d.parity_odd = parity_odd_i;
                    cfg_d.stop2      = stop2_i;
                    cfg_d.div        = UART_DIV_W'(baud_div_i);
                    state_d          = REQ;
                end
            end
            REQ: begin
                if (!tx_cts_n_i && tx_enable_i) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bitcnt_q == LAST_BIT) begin
                        bitcnt_d = '0;
                        state_d  = cfg_q.parity_en ? PARITY : STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    bitcnt_d = '0;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (cfg_q.stop2 && (bitcnt_q == '0)) begin
                        bitcnt_d = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = dpar_q ^ cfg_q.parity_odd;
            default: tx_d = 1'b1;
        endcase
        rts_n_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State, frame data and registered line outputs.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            dpar_q   <= 1'b0;
            tx_q     <= 1'b1;
            rts_n_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            dpar_q   <= dpar_d;
            tx_q     <= tx_d;
            rts_n_q  <= rts_n_d;
            busy_q   <= busy_d;
        end
    end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks framing, parity, stop bits, divisor
// edge cases, flow-control gating, back-to-back bytes and async reset.
module tb_uart_tx;

    logic        tck = 1'b0;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] baud_div_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        stop2_i;
    logic        tx_rts_n_o;
    logic        tx_cts_n_i;
    logic        tx_enable_i;
    logic        tx_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    uart_tx #(
        .DATA_W (8),
        .DIV_W  (16)
    ) dut (
        .tck          (tck),
        .rst          (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .baud_div_i   (baud_div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .tx_rts_n_o   (tx_rts_n_o),
        .tx_cts_n_i   (tx_cts_n_i),
        .tx_enable_i  (tx_enable_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample tx_o once per cycle across nb bits of eff cycles each.
    task automatic expect_bits(input string tag, input logic [11:0] bits,
                               input int nb, input int eff);
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < eff; c++) begin
                @(negedge tck);
                chk($sformatf("%s_b%0d_c%0d", tag, i, c), tx_o, bits[i]);
            end
        end
        chk({tag, "_rts_last"}, tx_rts_n_o, 1'b0);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge tck);
        chk({tag, "_idle_rts"},   tx_rts_n_o, 1'b1);
        chk({tag, "_idle_busy"},  busy_o,     1'b0);
        chk({tag, "_idle_ready"}, ready_o,    1'b1);
        chk({tag, "_idle_tx"},    tx_o,       1'b1);
    endtask

    // Accept one byte, scramble the config inputs, then check the frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                             input logic podd, input logic s2, input logic [15:0] div,
                             input logic [11:0] bits, input int nb);
        int eff;
        eff = (div == 16'd0) ? 1 : int'(div);
        @(negedge tck);
        data_i       = d;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop2_i      = s2;
        baud_div_i   = div;
        valid_i      = 1'b1;
        chk({tag, "_ready"}, ready_o, 1'b1);
        @(posedge tck);
        @(negedge tck);
        valid_i      = 1'b0;
        data_i       = ~d;
        parity_en_i  = ~pen;
        parity_odd_i = ~podd;
        stop2_i      = ~s2;
        baud_div_i   = div + 16'd3;
        chk({tag, "_req_rts"},   tx_rts_n_o, 1'b0);
        chk({tag, "_req_busy"},  busy_o,     1'b1);
        chk({tag, "_req_ready"}, ready_o,    1'b0);
        chk({tag, "_req_tx"},    tx_o,       1'b1);
        expect_bits(tag, bits, nb, eff);
        expect_idle(tag);
    endtask

    initial begin
        int k;
        rst          = 1'b1;
        data_i       = 8'h00;
        valid_i      = 1'b0;
        baud_div_i   = 16'd4;
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i      = 1'b0;
        tx_cts_n_i   = 1'b0;
        tx_enable_i  = 1'b1;

        // Reset state
        #1;
        chk("rst_tx",    tx_o,       1'b1);
        chk("rst_rts",   tx_rts_n_o, 1'b1);
        chk("rst_busy",  busy_o,     1'b0);
        chk("rst_ready", ready_o,    1'b0);
        repeat (2) @(negedge tck);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ready_o, 1'b1);

        // 0xA5, div 4: no parity / even / odd / even+2 stop
        run_frame("a5_plain", 8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, 12'h34A, 10);
        run_frame("a5_even",  8'hA5, 1'b1, 1'b0, 1'b0, 16'd4, 12'h54A, 11);
        run_frame("a5_odd",   8'hA5, 1'b1, 1'b1, 1'b0, 16'd4, 12'h74A, 11);
        run_frame("a5_stop2", 8'hA5, 1'b1, 1'b0, 1'b1, 16'd4, 12'hD4A, 12);

        // div 0 behaves as 1
        run_frame("div0", 8'h01, 1'b0, 1'b0, 1'b0, 16'd0, 12'h202, 10);

        // Grant withheld 20 cycles, then granted; grant lost mid-frame
        @(negedge tck);
        tx_cts_n_i   = 1'b1;
        data_i       = 8'h0F;
        baud_div_i   = 16'd2;
        parity_en_i  = 1'b0;
        stop2_i      = 1'b0;
        valid_i      = 1'b1;
        @(posedge tck);
        @(negedge tck);
        valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("hold_rts_%0d", i),   tx_rts_n_o, 1'b0);
            chk($sformatf("hold_tx_%0d", i),    tx_o,       1'b1);
            chk($sformatf("hold_ready_%0d", i), ready_o,    1'b0);
            @(negedge tck);
        end
        tx_cts_n_i = 1'b0;
        @(negedge tck);
        chk("grant_start_tx", tx_o, 1'b0);
        tx_cts_n_i  = 1'b1;
        tx_enable_i = 1'b0;
        k = 0;
        while (busy_o && k < 100) begin
            @(negedge tck);
            k++;
        end
        chk("grant_loss_len", k, 20);
        tx_cts_n_i  = 1'b0;
        tx_enable_i = 1'b1;

        // Back-to-back with valid held: 0x55 then 0xAA at div 1
        @(negedge tck);
        data_i     = 8'h55;
        baud_div_i = 16'd1;
        valid_i    = 1'b1;
        @(posedge tck);
        @(negedge tck);
        data_i = 8'hAA;
        chk("b2b_req1_rts", tx_rts_n_o, 1'b0);
        expect_bits("b2b_55", 12'h2AA, 10, 1);
        @(negedge tck);
        chk("b2b_gap_rts",   tx_rts_n_o, 1'b1);
        chk("b2b_gap_ready", ready_o,    1'b1);
        @(posedge tck);
        @(negedge tck);
        valid_i = 1'b0;
        chk("b2b_req2_rts", tx_rts_n_o, 1'b0);
        expect_bits("b2b_aa", 12'h354, 10, 1);
        expect_idle("b2b_end");

        // Async reset during the 3rd data bit of 0x00 at div 4
        @(negedge tck);
        data_i     = 8'h00;
        baud_div_i = 16'd4;
        valid_i    = 1'b1;
        @(posedge tck);
        @(negedge tck);
        valid_i = 1'b0;
        // START at next cycle; 3rd data bit spans frame cycles 12..15
        repeat (14) @(negedge tck);
        chk("mid_rst_pre_tx", tx_o, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx",    tx_o,       1'b1);
        chk("mid_rst_rts",   tx_rts_n_o, 1'b1);
        chk("mid_rst_busy",  busy_o,     1'b0);
        chk("mid_rst_ready", ready_o,    1'b0);
        repeat (2) @(negedge tck);
        rst = 1'b0;
        #1;
        chk("rel_ready", ready_o, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge tck);
            chk($sformatf("rel_tx_%0d", i),  tx_o,       1'b1);
            chk($sformatf("rel_rts_%0d", i), tx_rts_n_o, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer. It sits directly upstream of uart_flow_ctrl's TX interface. It accepts bytes over a valid/ready handshake and requests the line via tx_rts_n_o. It waits for tx_cts_n_i low and tx_enable_i from flow control, then shifts out the frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits, at a programmable baud divisor.

Parameters:
DATA_W, 8, data bits per frame
DIV_W, 16, width of baud divisor (tck cycles per bit)

Ports:
tck  in  1  clock
rst  in  1  asynchronous reset, active-high
data_i  in  DATA_W  byte to send
valid_i  in  1  data_i valid
ready_o  out  1  block can accept a byte
baud_div_i  in  DIV_W  tck cycles per bit; 0 is treated as 1
parity_en_i  in  1  append parity bit
parity_odd_i  in  1  1 = odd parity, 0 = even
stop2_i  in  1  1 = two stop bits
tx_rts_n_o  out  1  request to flow ctrl, active-low
tx_cts_n_i  in  1  grant from flow ctrl, active-low
tx_enable_i  in  1  TX port enabled by flow ctrl
tx_o  out  1  serial line, idle high
busy_o  out  1  frame pending or in flight

Behaviour:
- Reset (async, rst=1): state IDLE, tx_o=1, tx_rts_n_o=1, busy_o=0, ready_o=0 while rst is high. Shift register, bit counter and baud counter are cleared.
- States: IDLE, REQ, START, DATA, PARITY, STOP.
- IDLE:
  - ready_o=1, tx_rts_n_o=1, tx_o=1.
  - On valid_i&ready_o: latch data_i, parity_en_i, parity_odd_i, stop2_i and baud_div_i, then go to REQ.
  - Config changes after acceptance do not affect the frame in flight.
- REQ:
  - tx_rts_n_o=0, busy_o=1, tx_o=1, ready_o=0.
  - Go to START when tx_cts_n_i==0 and tx_enable_i==1; otherwise wait indefinitely (no timeout).
- START/DATA/PARITY/STOP:
  - tx_rts_n_o=0, busy_o=1, ready_o=0.
  - Each bit is held exactly max(div,1) tck cycles.
  - Baud counter is cleared on entry to START and wraps at div-1. The bit advances on wrap.
- Bit values:
  - START: tx_o=0.
  - DATA: tx_o = shift[0], LSB first; shift right on each bit advance. Exit after DATA_W bits.
  - PARITY: entered only if parity_en. Bit = XOR(data) ^ parity_odd.
  - STOP: tx_o=1 for 1 or 2 bit times. Then go to IDLE.
- Latency:
  - Acceptance in cycle N gives tx_rts_n_o low in N+1.
  - If grant is already present, START (tx_o=0) begins in N+2.
  - Frame duration = div*(1+DATA_W+P+S) cycles.
- Back-to-back: after STOP, one IDLE cycle with tx_rts_n_o=1 is guaranteed. This lets flow ctrl return to FC_IDLE before the next request.
- Grant loss mid-frame: if tx_cts_n_i rises or tx_enable_i falls after START, the current frame completes; no mid-frame abort.
- Reset mid-frame: the line returns high immediately and no partial frame resumes.
- All outputs are registered except ready_o, which is decoded from state.

Decomposition:
- Package uart_defs:
  - add TxState_t enum (IDLE, REQ, START, DATA, PARITY, STOP).
  - add constant UART_DATA_W=8.
  - add TxFrameCfg_t struct {parity_en, parity_odd, stop2, div}.
- Sub-module uart_baud_gen: a counter with clear, a divisor input (0 treated as 1) and a single-cycle tick output at wrap. It is reusable by uart_rx.

Test Plan:
- div=4, 0xA5, no parity, 1 stop, cts low, enable high -> tx_o bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; 40 cycles total; START 2 cycles after accept.
- 0xA5 with even parity -> parity bit 0; with odd parity -> parity bit 1; with stop2=1 -> 2 stop bits; 48 cycles at div=4.
- Hold tx_cts_n_i=1 for 20 cycles after accept -> state REQ, tx_rts_n_o=0, tx_o=1, ready_o=0. Drop cts -> tx_o=0 on the next cycle.
- div=0, byte 0x01 -> each bit is 1 cycle; frame is 10 cycles; sequence 0,1,0,0,0,0,0,0,0,1.
- valid_i held with two bytes 0x55, 0xAA -> second accepted in the cycle after STOP ends; tx_rts_n_o high for exactly 1 cycle between frames.
- Assert rst during the 3rd data bit -> tx_o=1, tx_rts_n_o=1, busy_o=0 in the same cycle (async); after release, ready_o=1 and no residual bits.
